booth_divide_seq: RTL and testbench

- Multi-cycle signed integer divider; the inverse datapath to the combinational Booth multiplier in the ALU.
- Shift/subtract (restoring) algorithm, one quotient bit per clock.
- Produces a 2*BITS result laid out HI/LO: remainder in the upper half, quotient in the lower half. It feeds the same HI/LO register pair as multiply.
- The control unit launches it with a start pulse and stalls on busy until done.

---
 rtl/booth_divide_seq.sv | 164 ++++++++++++++++
 tb/tb_booth_divide_seq.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/booth_divide_seq.sv
// booth_divide_seq
//   Multi-cycle signed integer divider (restoring shift/subtract), one
//   quotient bit per clock. The result is laid out HI/LO so it can feed the
//   same HI/LO register pair as the multiplier.
//
//   Optional build macro: DIV_EARLY_EXIT_EN
//     When defined, an operation with |dividend| < |divisor| skips CALC and
//     goes straight to sign correction. Results are identical either way.
//
// Parameters
//   BITS       operand width (even, >= 4)
// Ports
//   clk        system clock, rising edge
//   clr        asynchronous active-high reset
//   start      launch request, sampled only in IDLE
//   dividend   signed dividend, two's complement
//   divisor    signed divisor, two's complement
//   outputDiv  {remainder, quotient}; held until the next result is written
//   busy       high while in CALC or FIX
//   done       one-cycle pulse, outputDiv valid from this cycle
//   div_zero   sticky divide-by-zero flag, cleared on the next accepted start
module booth_divide_seq #(
    parameter int BITS = 32
) (
    input  logic                clk,
    input  logic                clr,
    input  logic                start,
    input  logic [BITS-1:0]     dividend,
    input  logic [BITS-1:0]     divisor,
    output logic [2*BITS-1:0]   outputDiv,
    output logic                busy,
    output logic                done,
    output logic                div_zero
);

    localparam int CW = $clog2(BITS);
    localparam logic [CW-1:0] LAST_ITER = CW'(BITS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_t;

    state_t          state_q;
    logic            dvd_neg_q;
    logic            dvs_neg_q;
    logic [BITS:0]   dvs_mag_q;
    logic [BITS-1:0] rem_q;
    logic [BITS-1:0] quo_q;
    logic [CW-1:0]   cnt_q;
    logic [2*BITS-1:0] out_q;
    logic            busy_q;
    logic            done_q;
    logic            dz_q;

    logic [BITS-1:0] dvd_mag_d;
    logic [BITS-1:0] dvs_mag_d;
    logic [BITS:0]   shift_d;
    logic [BITS:0]   diff_d;
    logic            ge_d;
    logic [BITS-1:0] rem_next_d;
    logic [BITS-1:0] quo_next_d;
    logic [BITS-1:0] q_fix_d;
    logic [BITS-1:0] r_fix_d;

    always_comb begin
        // Magnitudes as unsigned BITS-bit values; the most-negative input
        // maps to 2^(BITS-1), which is representable unsigned.
        dvd_mag_d = dividend[BITS-1] ? -dividend : dividend;
        dvs_mag_d = divisor[BITS-1]  ? -divisor  : divisor;

        // quo_q starts as |dividend| and shifts its MSB into the remainder
        // while quotient bits fill in from the LSB.
        shift_d = {rem_q, quo_q[BITS-1]};
        diff_d  = shift_d - dvs_mag_q;
        // shift_d < 2*|divisor| <= 2^BITS, so a negative difference is at
        // least -2^(BITS-1) and its MSB reliably flags the borrow.
        ge_d       = ~diff_d[BITS];
        rem_next_d = ge_d ? diff_d[BITS-1:0] : shift_d[BITS-1:0];
        quo_next_d = {quo_q[BITS-2:0], ge_d};

        q_fix_d = (dvd_neg_q ^ dvs_neg_q) ? -quo_q : quo_q;
        r_fix_d = dvd_neg_q ? -rem_q : rem_q;
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= S_IDLE;
            dvd_neg_q <= 1'b0;
            dvs_neg_q <= 1'b0;
            dvs_mag_q <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            cnt_q     <= '0;
            out_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        dvd_neg_q <= dividend[BITS-1];
                        dvs_neg_q <= divisor[BITS-1];
                        dvs_mag_q <= {1'b0, dvs_mag_d};
                        rem_q     <= '0;
                        quo_q     <= dvd_mag_d;
                        cnt_q     <= '0;
                        dz_q      <= 1'b0;
                        if (divisor == '0) begin
                            dz_q    <= 1'b1;
                            done_q  <= 1'b1;
                            out_q   <= {dividend, {BITS{1'b1}}};
                            state_q <= S_DONE;
`ifdef DIV_EARLY_EXIT_EN
                        end else if (dvd_mag_d < dvs_mag_d) begin
                            // Quotient is zero and the remainder is the
                            // dividend; FIX restores the dividend's sign.
                            rem_q   <= dvd_mag_d;
                            quo_q   <= '0;
                            busy_q  <= 1'b1;
                            state_q <= S_FIX;
`endif
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_CALC;
                        end
                    end
                end
                S_CALC: begin
                    rem_q <= rem_next_d;
                    quo_q <= quo_next_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_q <= S_FIX;
                    end
                end
                S_FIX: begin
                    out_q   <= {r_fix_d, q_fix_d};
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    state_q <= S_DONE;
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign outputDiv = out_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign div_zero  = dz_q;

endmodule

// File: tb/tb_booth_divide_seq.sv
// tb_booth_divide_seq
//   Directed bench for booth_divide_seq (BITS=32). Expected results are
//   hand-computed constants; latency of the short-operand cases depends on
//   DIV_EARLY_EXIT_EN.
module tb_booth_divide_seq;

    localparam int BITS = 32;
    localparam int FULL_LAT = BITS + 2;
`ifdef DIV_EARLY_EXIT_EN
    localparam int SHORT_LAT = 2;
`else
    localparam int SHORT_LAT = FULL_LAT;
`endif

    logic              clk = 1'b0;
    logic              clr;
    logic              start;
    logic [BITS-1:0]   dividend;
    logic [BITS-1:0]   divisor;
    logic [2*BITS-1:0] outputDiv;
    logic              busy;
    logic              done;
    logic              div_zero;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    booth_divide_seq #(.BITS(BITS)) dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .outputDiv (outputDiv),
        .busy      (busy),
        .done      (done),
        .div_zero  (div_zero)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Present operands and start before the accepting edge E0; drop start after it.
    task automatic launch(input logic [BITS-1:0] a, input logic [BITS-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Cycle n is the cycle after edge E(n-1). Busy must be high in every
    // cycle before done and low in the done cycle. Optionally re-pulses
    // start with other operands at cycle inj_at.
    task automatic wait_done(input int inj_at, output int lat, output int busy_bad);
        lat = -1;
        busy_bad = 0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (done === 1'b1) begin
                lat = n;
                if (busy !== 1'b0) busy_bad++;
                break;
            end
            if (busy !== 1'b1) busy_bad++;
            if (n == inj_at) begin
                dividend = 32'd50;
                divisor  = 32'd5;
                start    = 1'b1;
            end
            if (n == inj_at + 1) start = 1'b0;
        end
        start = 1'b0;
    endtask

    task automatic run(input string tag, input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                       input logic [63:0] exp_out, input logic exp_dz, input int exp_lat);
        int lat;
        int bb;
        launch(a, b);
        wait_done(-5, lat, bb);
        chk({tag, "_out"}, outputDiv, exp_out);
        chk({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        chk({tag, "_busy"}, 64'(bb), 64'd0);
        chk({tag, "_dz"}, {63'd0, div_zero}, {63'd0, exp_dz});
        @(negedge clk);
        chk({tag, "_done_once"}, {62'd0, done, busy}, 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int lat;
        int bb;
        int pulses;

        clr      = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        chk("rst_out", outputDiv, 64'd0);
        chk("rst_flags", {61'd0, busy, done, div_zero}, 64'd0);
        @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        chk("idle_after_rst", {outputDiv[61:0], busy, done}, 64'd0);

        run("pos_pos", 32'd100, 32'd7, {32'd2, 32'd14}, 1'b0, FULL_LAT);
        run("neg_pos", -32'sd100, 32'd7, {32'hFFFFFFFE, 32'hFFFFFFF2}, 1'b0, FULL_LAT);
        run("pos_neg", 32'd100, -32'sd7, {32'd2, 32'hFFFFFFF2}, 1'b0, FULL_LAT);
        run("neg_neg", -32'sd100, -32'sd7, {32'hFFFFFFFE, 32'd14}, 1'b0, FULL_LAT);
        run("ovf_m1", 32'h80000000, 32'hFFFFFFFF, {32'd0, 32'h80000000}, 1'b0, FULL_LAT);
        run("min_p1", 32'h80000000, 32'd1, {32'd0, 32'h80000000}, 1'b0, FULL_LAT);
        run("equal", 32'd7, 32'd7, {32'd0, 32'd1}, 1'b0, FULL_LAT);

        run("dz", 32'd5, 32'd0, {32'd5, 32'hFFFFFFFF}, 1'b1, 1);
        chk("dz_sticky", {63'd0, div_zero}, 64'd1);
        run("after_dz", 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, FULL_LAT);

        run("short", 32'd3, 32'd7, {32'd3, 32'd0}, 1'b0, SHORT_LAT);
        run("short_neg", 32'hFFFFFFFF, 32'd2, {32'hFFFFFFFF, 32'd0}, 1'b0, SHORT_LAT);
        run("short_max", 32'h7FFFFFFF, 32'h80000000, {32'h7FFFFFFF, 32'd0}, 1'b0, SHORT_LAT);

        // Start while busy: a second request at cycle 10 must be ignored and
        // the previous result must hold during CALC.
        run("pre_busy", 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, FULL_LAT);
        launch(32'd1000, 32'd3);
        repeat (5) @(negedge clk);
        chk("hold_in_calc", outputDiv, {32'd0, 32'd3});
        wait_done(5, lat, bb);
        chk("busy_restart_out", outputDiv, {32'd1, 32'd333});
        chk("busy_restart_lat", 64'(lat + 5), 64'(FULL_LAT));
        chk("busy_restart_busy", 64'(bb), 64'd0);
        @(negedge clk);
        chk("busy_restart_once", {62'd0, done, busy}, 64'd0);

        // Reset mid-operation.
        launch(32'd1000, 32'd3);
        repeat (20) @(negedge clk);
        clr = 1'b1;
        #1;
        chk("clr_mid_out", outputDiv, 64'd0);
        chk("clr_mid_flags", {61'd0, busy, done, div_zero}, 64'd0);
        @(negedge clk);
        clr = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) pulses++;
        end
        chk("clr_no_done", 64'(pulses), 64'd0);
        run("after_clr", 32'd9, 32'd3, {32'd0, 32'd3}, 1'b0, FULL_LAT);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
